// File: rtl/alu4_result_buffer.sv
// Two-entry elastic result buffer behind the ALU result-select mux: stores result, carry and zero flag.
// Define ALU4_RESULT_PARITY_EN to add a per-entry parity bit on out_parity.
module alu4_result_buffer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic [1:0]       out_count,
    output logic             protocol_err
`ifdef ALU4_RESULT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_result_q [2];
    logic [1:0]       mem_carry_q;
    logic [1:0]       mem_zero_q;
`ifdef ALU4_RESULT_PARITY_EN
    logic [1:0]       mem_parity_q;
`endif

    logic             stall_q;
    logic [WIDTH-1:0] prev_result_q;
    logic             prev_carry_q;
    logic             protocol_err_q, protocol_err_d;

    logic             push, pop, write_en;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign write_en = push & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            state_d  = EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case (state_q)
                EMPTY: if (push) state_d = ONE;
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (!push && pop) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q != FULL);
        out_valid  = (state_q != EMPTY);
        out_count  = state_q;
        out_result = mem_result_q[rd_ptr_q];
        out_carry  = mem_carry_q[rd_ptr_q];
        out_zero   = mem_zero_q[rd_ptr_q];
`ifdef ALU4_RESULT_PARITY_EN
        out_parity = mem_parity_q[rd_ptr_q];
`endif
    end

    // NOTE: the storage is small and must read back as zero after reset, so it is reset like any register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_result_q[i] <= '0;
            mem_carry_q  <= '0;
            mem_zero_q   <= '0;
`ifdef ALU4_RESULT_PARITY_EN
            mem_parity_q <= '0;
`endif
        end else if (write_en) begin
            mem_result_q[wr_ptr_q] <= in_result;
            mem_carry_q[wr_ptr_q]  <= in_carry;
            mem_zero_q[wr_ptr_q]   <= ~|in_result;
`ifdef ALU4_RESULT_PARITY_EN
            mem_parity_q[wr_ptr_q] <= ^in_result;
`endif
        end
    end

    // A stalled offer must be held stable until accepted; withdrawing or changing it is sticky.
    always_comb begin
        protocol_err_d = protocol_err_q;
        if (stall_q && (!in_valid || (in_result != prev_result_q) || (in_carry != prev_carry_q)))
            protocol_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q        <= 1'b0;
            prev_result_q  <= '0;
            prev_carry_q   <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            stall_q        <= in_valid & ~in_ready;
            prev_result_q  <= in_result;
            prev_carry_q   <= in_carry;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_alu4_result_buffer.sv
// Self-checking bench for alu4_result_buffer: scenario tasks plus a FIFO scoreboard on the output side.
// Parity checks are compiled in when ALU4_RESULT_PARITY_EN is defined.
module tb_alu4_result_buffer;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             parity;
    } entry_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic [1:0]       out_count;
    logic             protocol_err;
`ifdef ALU4_RESULT_PARITY_EN
    logic             out_parity;
`endif

    int     errors = 0;
    int     checks = 0;
    int     sb_pops = 0;
    entry_t sb_q[$];

    alu4_result_buffer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_count    (out_count),
        .protocol_err (protocol_err)
`ifdef ALU4_RESULT_PARITY_EN
        ,
        .out_parity   (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen here are the ones the next edge commits.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: got pop of %h, want no pop", out_result);
                    end else begin
                        entry_t e;
                        e = sb_q.pop_front();
                        sb_pops++;
                        if ({out_result, out_carry, out_zero} !== {e.result, e.carry, e.zero}) begin
                            errors++;
                            $display("FAIL sb_head: got r=%h c=%b z=%b, want r=%h c=%b z=%b",
                                     out_result, out_carry, out_zero, e.result, e.carry, e.zero);
                        end
`ifdef ALU4_RESULT_PARITY_EN
                        checks++;
                        if (out_parity !== e.parity) begin
                            errors++;
                            $display("FAIL sb_parity: got %b want %b", out_parity, e.parity);
                        end
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    entry_t n;
                    n.result = in_result;
                    n.carry  = in_carry;
                    n.zero   = (in_result == '0);
                    n.parity = ^in_result;
                    sb_q.push_back(n);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc(2);
        checks++;
        if ({out_valid, in_ready, out_count, protocol_err} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b rdy=%b cnt=%0d err=%b, want v=0 rdy=1 cnt=0 err=0",
                     out_valid, in_ready, out_count, protocol_err);
        end
        checks++;
        if ({out_result, out_carry, out_zero} !== {4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_data: got r=%h c=%b z=%b, want 0 0 0", out_result, out_carry, out_zero);
        end
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_pass_through;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = 4'hA;
        in_carry  = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_result, out_carry, out_zero} !== {1'b1, 4'hA, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pass_head: got v=%b r=%h c=%b z=%b, want v=1 r=a c=1 z=0",
                     out_valid, out_result, out_carry, out_zero);
        end
        cyc(1);
        checks++;
        if ({out_valid, out_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL pass_drain: got v=%b cnt=%0d, want v=0 cnt=0", out_valid, out_count);
        end
    endtask

    task automatic test_fill_stall;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_carry  = 1'b0;
        in_result = 4'h0;
        cyc(1);
        in_result = 4'h5;
        in_carry  = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        checks++;
        if ({out_count, in_ready, out_valid} !== {2'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b v=%b, want cnt=2 rdy=0 v=1", out_count, in_ready, out_valid);
        end
        checks++;
        if ({out_result, out_zero} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL fill_head: got r=%h z=%b, want r=0 z=1", out_result, out_zero);
        end
        cyc(1);
        checks++;
        if ({out_result, out_zero, out_count} !== {4'h0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL stall_hold: got r=%h z=%b cnt=%0d, want r=0 z=1 cnt=2", out_result, out_zero, out_count);
        end
        out_ready = 1'b1;
        cyc(1);
        checks++;
        if ({out_result, out_carry, out_count} !== {4'h5, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL drain_second: got r=%h c=%b cnt=%0d, want r=5 c=1 cnt=1", out_result, out_carry, out_count);
        end
        cyc(1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int pops_before;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 4'h3;
        in_carry  = 1'b0;
        cyc(1);
        out_ready = 1'b1;
        in_result = 4'hF;
        cyc(1);
        in_valid = 1'b0;
        checks++;
        if ({out_count, out_result} !== {2'd1, 4'hF}) begin
            errors++;
            $display("FAIL simul_pushpop: got cnt=%0d r=%h, want cnt=1 r=f", out_count, out_result);
        end
        cyc(1);
        pops_before = sb_pops;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_result = WIDTH'(i + 2);
            in_carry  = i[0];
            cyc(1);
            checks++;
            if ({out_valid, out_count, out_result} !== {1'b1, 2'd1, WIDTH'(i + 2)}) begin
                errors++;
                $display("FAIL b2b_word%0d: got v=%b cnt=%0d r=%h, want v=1 cnt=1 r=%h",
                         i, out_valid, out_count, out_result, WIDTH'(i + 2));
            end
        end
        in_valid = 1'b0;
        cyc(1);
        checks++;
        if ((sb_pops - pops_before) != 10 || out_count !== 2'd0) begin
            errors++;
            $display("FAIL b2b_total: got pops=%0d cnt=%0d, want pops=10 cnt=0", sb_pops - pops_before, out_count);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_carry  = 1'b0;
        in_result = 4'h1;
        cyc(1);
        in_result = 4'h2;
        cyc(1);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_result = 4'h9;
        cyc(1);
        flush = 1'b0;
        checks++;
        if ({out_count, out_valid, in_ready} !== {2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush_clear: got cnt=%0d v=%b rdy=%b, want cnt=0 v=0 rdy=1", out_count, out_valid, in_ready);
        end
        // The held offer is now accepted normally, landing in slot 0 after the pointer clear.
        cyc(1);
        in_valid = 1'b0;
        checks++;
        if ({out_count, out_result, protocol_err} !== {2'd1, 4'h9, 1'b0}) begin
            errors++;
            $display("FAIL flush_after: got cnt=%0d r=%h err=%b, want cnt=1 r=9 err=0", out_count, out_result, protocol_err);
        end
        cyc(1);
    endtask

`ifdef ALU4_RESULT_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_carry  = 1'b0;
        in_result = 4'h7;
        cyc(1);
        out_ready = 1'b1;
        checks++;
        if (out_parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_7: got %b want 1", out_parity);
        end
        in_result = 4'h6;
        cyc(1);
        in_valid = 1'b0;
        checks++;
        if ({out_result, out_parity} !== {4'h6, 1'b0}) begin
            errors++;
            $display("FAIL parity_6: got r=%h p=%b, want r=6 p=0", out_result, out_parity);
        end
        cyc(1);
    endtask
`endif

    task automatic test_protocol;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_carry  = 1'b0;
        in_result = 4'h1;
        cyc(1);
        in_result = 4'h2;
        cyc(1);
        in_result = 4'h7;
        cyc(2);
        checks++;
        if ({protocol_err, out_count} !== {1'b0, 2'd2}) begin
            errors++;
            $display("FAIL proto_hold: got err=%b cnt=%0d, want err=0 cnt=2", protocol_err, out_count);
        end
        in_result = 4'h8;
        cyc(1);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_set: got %b want 1", protocol_err);
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(1);
        checks++;
        if ({protocol_err, out_count} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL proto_sticky: got err=%b cnt=%0d, want err=1 cnt=0", protocol_err, out_count);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 4'hC;
        in_carry  = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if ({out_valid, out_count, in_ready, protocol_err, out_result} !== {1'b0, 2'd0, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_async: got v=%b cnt=%0d rdy=%b err=%b r=%h, want 0 0 1 0 0",
                     out_valid, out_count, in_ready, protocol_err, out_result);
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if ({out_valid, out_count} !== {1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_release: got v=%b cnt=%0d, want 0 0", out_valid, out_count);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_pass_through();
        test_fill_stall();
        test_back_to_back();
        test_flush();
`ifdef ALU4_RESULT_PARITY_EN
        test_parity();
`endif
        test_protocol();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
